// File: rtl/gshare_btb_predictor.sv
// Gshare branch predictor: 2-bit PHT indexed by pc^GHR, speculative history with
// misprediction repair, and an optional direct-mapped BTB enabled by macro BP_BTB_EN.
module gshare_btb_predictor #(
  parameter int PC_W      = 32,
  parameter int GHR_W     = 8,
  parameter int PHT_IDX_W = 8,
  parameter int BTB_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid,
  input  logic [PC_W-1:0]      lookup_pc,
  input  logic [1:0]           lookup_kind,
  output logic                 pred_taken,
  output logic [PC_W-1:0]      pred_target,
  output logic [PHT_IDX_W-1:0] pred_pht_idx,
  output logic [GHR_W-1:0]     pred_ghr,
  input  logic                 upd_valid,
  input  logic [PC_W-1:0]      upd_pc,
  input  logic [1:0]           upd_kind,
  input  logic                 upd_taken,
  input  logic [PC_W-1:0]      upd_target,
  input  logic [PHT_IDX_W-1:0] upd_pht_idx,
  input  logic [GHR_W-1:0]     upd_ghr,
  input  logic                 upd_mispredict,
  output logic [CNT_W-1:0]     perf_lookups,
  output logic [CNT_W-1:0]     perf_mispredicts
);
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;

  genvar gi;

  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic [CNT_W-1:0]     lookups_q, lookups_d;
  logic [CNT_W-1:0]     mispredicts_q, mispredicts_d;
  logic [PHT_IDX_W-1:0] ghr_ext, lk_idx;
  logic [PC_W-1:0]      seq_pc, hit_tgt;
  logic                 dir_qual, jmp_hit;
  logic [1:0]           pht_cnt [PHT_N];
  logic [1:0]           upd_cnt_next;
  logic                 pht_we;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr_q;
    lk_idx = lookup_pc[PHT_IDX_W+1:2] ^ ghr_ext;
  end

  assign seq_pc = lookup_pc + PC_W'(4);
  assign pht_we = upd_valid && (upd_kind == KIND_BR);

  // One shared saturating adder; the selected entry just loads its result.
  always_comb begin
    upd_cnt_next = pht_cnt[upd_pht_idx];
    if (upd_taken && upd_cnt_next != 2'b11) begin
      upd_cnt_next = upd_cnt_next + 2'b01;
    end else if (!upd_taken && upd_cnt_next != 2'b00) begin
      upd_cnt_next = upd_cnt_next - 2'b01;
    end
  end

  for (gi = 0; gi < PHT_N; gi++) begin : g_pht
    logic [1:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (pht_we && upd_pht_idx == PHT_IDX_W'(gi)) cnt_d = upd_cnt_next;
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= 2'b01;
      else     cnt_q <= cnt_d;
    end
    assign pht_cnt[gi] = cnt_q;
  end

`ifdef BP_BTB_EN
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = PC_W - BTB_IDX_W - 2;

  logic                 btb_valid [BTB_N];
  logic [TAG_W-1:0]     btb_tag   [BTB_N];
  logic [PC_W-1:0]      btb_tgt   [BTB_N];
  logic [BTB_IDX_W-1:0] lk_btb_idx, upd_btb_idx;
  logic                 btb_we, lk_hit;
  logic                 unused_upd;

  assign lk_btb_idx  = lookup_pc[BTB_IDX_W+1:2];
  assign upd_btb_idx = upd_pc[BTB_IDX_W+1:2];
  assign btb_we      = upd_valid && (upd_kind != KIND_NONE) && upd_taken;
  assign lk_hit      = btb_valid[lk_btb_idx] &&
                       (btb_tag[lk_btb_idx] == lookup_pc[PC_W-1:BTB_IDX_W+2]);
  assign unused_upd  = ^upd_pc[1:0];

  for (gi = 0; gi < BTB_N; gi++) begin : g_btb
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      if (btb_we && upd_btb_idx == BTB_IDX_W'(gi)) begin
        valid_d = 1'b1;
        tag_d   = upd_pc[PC_W-1:BTB_IDX_W+2];
        tgt_d   = upd_target;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= valid_d;
    end
    // Tag and target are only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
    end
    assign btb_valid[gi] = valid_q;
    assign btb_tag[gi]   = tag_q;
    assign btb_tgt[gi]   = tgt_q;
  end

  assign dir_qual = lk_hit;
  assign jmp_hit  = lk_hit;
  assign hit_tgt  = btb_tgt[lk_btb_idx];
`else
  logic unused_upd;
  assign unused_upd = ^{upd_pc, upd_target};
  // Without a BTB, decode supplies taken targets, so fetch always falls through.
  assign dir_qual = 1'b1;
  assign jmp_hit  = 1'b0;
  assign hit_tgt  = seq_pc;
`endif

  always_comb begin
    pred_taken = 1'b0;
    if (lookup_valid) begin
      case (lookup_kind)
        KIND_BR:  pred_taken = pht_cnt[lk_idx][1] && dir_qual;
        KIND_NONE: pred_taken = 1'b0;
        default:  pred_taken = jmp_hit;
      endcase
    end
    pred_target  = pred_taken ? hit_tgt : seq_pc;
    pred_pht_idx = lk_idx;
    pred_ghr     = ghr_q;
  end

  // Repair is applied after the speculative shift so it wins in the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (lookup_valid && lookup_kind == KIND_BR) ghr_d = GHR_W'({ghr_q, pred_taken});
    if (upd_valid && upd_mispredict) begin
      if (upd_kind == KIND_BR)        ghr_d = GHR_W'({upd_ghr, upd_taken});
      else if (upd_kind != KIND_NONE) ghr_d = upd_ghr;
    end
  end

  always_comb begin
    lookups_d     = lookups_q;
    mispredicts_d = mispredicts_q;
    if (lookup_valid && lookup_kind == KIND_BR && lookups_q != '1)
      lookups_d = lookups_q + CNT_W'(1);
    if (upd_valid && upd_mispredict && mispredicts_q != '1)
      mispredicts_d = mispredicts_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q         <= '0;
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      ghr_q         <= ghr_d;
      lookups_q     <= lookups_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign perf_lookups     = lookups_q;
  assign perf_mispredicts = mispredicts_q;
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor: directed scenarios plus randomized
// traffic against a behavioural model; follows the BP_BTB_EN build setting.
module tb_gshare_btb_predictor;
  localparam int PC_W = 32, GHR_W = 8, PHT_IDX_W = 8, BTB_IDX_W = 4, CNT_W = 32;
`ifdef BP_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, lookup_valid, upd_valid, upd_taken, upd_mispredict;
  logic [31:0] lookup_pc, upd_pc, upd_target, pred_target, s_pred_target;
  logic [1:0]  lookup_kind, upd_kind;
  logic [7:0]  upd_pht_idx, upd_ghr, pred_pht_idx, pred_ghr, s_pred_pht_idx, s_pred_ghr;
  logic        pred_taken, s_pred_taken;
  logic [31:0] perf_lookups, perf_mispredicts;
  logic [3:0]  s_perf_lookups, s_perf_mispredicts;

  gshare_btb_predictor #(.PC_W(PC_W), .GHR_W(GHR_W), .PHT_IDX_W(PHT_IDX_W),
                         .BTB_IDX_W(BTB_IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .lookup_kind(lookup_kind), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_pht_idx(pred_pht_idx), .pred_ghr(pred_ghr), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_kind(upd_kind), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pht_idx(upd_pht_idx), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
    .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts));

  gshare_btb_predictor #(.PC_W(PC_W), .GHR_W(GHR_W), .PHT_IDX_W(PHT_IDX_W),
                         .BTB_IDX_W(BTB_IDX_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .lookup_kind(lookup_kind), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .pred_pht_idx(s_pred_pht_idx), .pred_ghr(s_pred_ghr), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_kind(upd_kind), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pht_idx(upd_pht_idx), .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
    .perf_lookups(s_perf_lookups), .perf_mispredicts(s_perf_mispredicts));

  int checks = 0;
  int failures = 0;

  // Behavioural model: plain integers and arrays.
  int          m_pht [256];
  int          m_ghr;
  bit          m_bv [16];
  logic [31:0] m_btag [16];
  logic [31:0] m_btgt [16];
  longint      m_lk, m_mis, m_slk, m_smis;

  function automatic void model_predict(output bit t, output logic [31:0] tgt, output int idx);
    int bi;
    bit hit;
    idx = int'((lookup_pc >> 2) & 32'hFF) ^ m_ghr;
    bi  = int'((lookup_pc >> 2) & 32'hF);
    hit = BTB_ON && m_bv[bi] && (m_btag[bi] == (lookup_pc >> 6));
    t   = 1'b0;
    if (lookup_valid) begin
      if (lookup_kind == 2'd1)      t = (m_pht[idx] >= 2) && (hit || !BTB_ON);
      else if (lookup_kind >= 2'd2) t = hit;
    end
    tgt = (t && BTB_ON) ? m_btgt[bi] : lookup_pc + 32'd4;
  endfunction

  function automatic void model_commit();
    bit t;
    logic [31:0] tgt;
    int idx, ng, bi;
    if (rst) begin
      foreach (m_pht[i]) m_pht[i] = 1;
      foreach (m_bv[i]) m_bv[i] = 1'b0;
      m_ghr = 0; m_lk = 0; m_mis = 0; m_slk = 0; m_smis = 0;
      return;
    end
    model_predict(t, tgt, idx);
    ng = m_ghr;
    if (lookup_valid && lookup_kind == 2'd1) begin
      ng = (m_ghr * 2 + int'(t)) % 256;
      if (m_lk < 64'hFFFF_FFFF) m_lk++;
      if (m_slk < 15) m_slk++;
    end
    if (upd_valid) begin
      if (upd_kind == 2'd1) begin
        if (upd_taken) m_pht[upd_pht_idx] = (m_pht[upd_pht_idx] < 3) ? m_pht[upd_pht_idx] + 1 : 3;
        else           m_pht[upd_pht_idx] = (m_pht[upd_pht_idx] > 0) ? m_pht[upd_pht_idx] - 1 : 0;
      end
      if (upd_kind != 2'd0 && upd_taken) begin
        bi = int'((upd_pc >> 2) & 32'hF);
        m_bv[bi] = 1'b1; m_btag[bi] = upd_pc >> 6; m_btgt[bi] = upd_target;
      end
      if (upd_mispredict) begin
        if (m_mis < 64'hFFFF_FFFF) m_mis++;
        if (m_smis < 15) m_smis++;
        if (upd_kind == 2'd1)      ng = (int'(upd_ghr) * 2 + int'(upd_taken)) % 256;
        else if (upd_kind >= 2'd2) ng = int'(upd_ghr);
      end
    end
    m_ghr = ng;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    rst = 0; lookup_valid = 0; lookup_pc = 0; lookup_kind = 0;
    upd_valid = 0; upd_pc = 0; upd_kind = 0; upd_taken = 0; upd_target = 0;
    upd_pht_idx = 0; upd_ghr = 0; upd_mispredict = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); idle();
  endtask

  task automatic set_lookup(input logic [31:0] pc, input logic [1:0] kind);
    lookup_valid = 1; lookup_pc = pc; lookup_kind = kind;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [1:0] kind, input logic taken,
                         input logic [31:0] tgt, input logic [7:0] idx, input logic [7:0] ghr,
                         input logic misp);
    upd_valid = 1; upd_pc = pc; upd_kind = kind; upd_taken = taken; upd_target = tgt;
    upd_pht_idx = idx; upd_ghr = ghr; upd_mispredict = misp;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); idle();
    set_lookup(32'h100, 2'd1); #1;
    $display("txn reset lookup pc=100 -> t=%0d tgt=%h ghr=%h", pred_taken, pred_target, pred_ghr);
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%0d exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL reset_target got=%h exp=104", pred_target); end
    checks++; if (pred_ghr !== 8'h00) begin failures++; $display("FAIL reset_ghr got=%h exp=00", pred_ghr); end
    checks++; if (pred_pht_idx !== 8'h40) begin failures++; $display("FAIL reset_idx got=%h exp=40", pred_pht_idx); end
    checks++; if (perf_lookups !== 32'd0) begin failures++; $display("FAIL reset_perf_lk got=%0d exp=0", perf_lookups); end
    checks++; if (perf_mispredicts !== 32'd0) begin failures++; $display("FAIL reset_perf_mis got=%0d exp=0", perf_mispredicts); end
    tick(); idle(); #1;
    checks++; if (perf_lookups !== 32'd1) begin failures++; $display("FAIL lookup_count got=%0d exp=1", perf_lookups); end
  endtask

  task automatic test_training();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_upd(32'h40, 2'd1, 1'b1, 32'h80, 8'h10, 8'h00, 1'b0); tick();
    end
    idle(); set_lookup(32'h40, 2'd1); #1;
    $display("txn train lookup pc=40 -> t=%0d tgt=%h", pred_taken, pred_target);
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL train_taken got=%0d exp=1", pred_taken); end
    checks++; if (pred_target !== (BTB_ON ? 32'h80 : 32'h44)) begin failures++; $display("FAIL train_target got=%h", pred_target); end
    tick(); idle();
    // Not-taken mispredict: counter 3->2 and history restored to {0,0}.
    set_upd(32'h40, 2'd1, 1'b0, 32'h80, 8'h10, 8'h00, 1'b1); tick(); idle();
    set_lookup(32'h40, 2'd1); #1;
    $display("txn train2 lookup pc=40 -> t=%0d ghr=%h", pred_taken, pred_ghr);
    checks++; if (pred_ghr !== 8'h00) begin failures++; $display("FAIL train_ghr got=%h exp=00", pred_ghr); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL train_weak_taken got=%0d exp=1", pred_taken); end
    tick(); idle();
  endtask

  task automatic test_spec_history();
    logic [7:0] exp_ghr [4];
    bit         exp_t [4];
    exp_ghr = '{8'h00, 8'h01, 8'h02, 8'h05};
    exp_t   = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_upd(32'h40, 2'd1, 1'b1, 32'h80, (i < 2) ? 8'h10 : (i < 4) ? 8'h12 : 8'h15, 8'h00, 1'b0);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      set_lookup(32'h40, 2'd1); #1;
      $display("txn spec[%0d] -> t=%0d ghr=%h", i, pred_taken, pred_ghr);
      checks++; if (pred_ghr !== exp_ghr[i]) begin failures++; $display("FAIL spec_ghr[%0d] got=%h exp=%h", i, pred_ghr, exp_ghr[i]); end
      checks++; if (pred_taken !== exp_t[i]) begin failures++; $display("FAIL spec_taken[%0d] got=%0d exp=%0d", i, pred_taken, exp_t[i]); end
      tick();
    end
    idle(); #1;
    checks++; if (pred_ghr !== 8'h0B) begin failures++; $display("FAIL spec_final_ghr got=%h exp=0b", pred_ghr); end
  endtask

  task automatic test_repair();
    checks++; if (perf_mispredicts !== 32'd0) begin failures++; $display("FAIL repair_mis_before got=%0d exp=0", perf_mispredicts); end
    set_lookup(32'h40, 2'd1);
    set_upd(32'h40, 2'd1, 1'b0, 32'h0, 8'h33, 8'h05, 1'b1);
    tick(); idle(); #1;
    $display("txn repair -> ghr=%h mis=%0d", pred_ghr, perf_mispredicts);
    checks++; if (pred_ghr !== 8'h0A) begin failures++; $display("FAIL repair_ghr got=%h exp=0a", pred_ghr); end
    checks++; if (perf_mispredicts !== 32'd1) begin failures++; $display("FAIL repair_mis got=%0d exp=1", perf_mispredicts); end
    set_upd(32'h40, 2'd3, 1'b1, 32'h900, 8'h00, 8'h77, 1'b1); tick(); idle(); #1;
    checks++; if (pred_ghr !== 8'h77) begin failures++; $display("FAIL repair_jalr_ghr got=%h exp=77", pred_ghr); end
  endtask

  task automatic test_btb_conflict();
    do_reset();
    set_upd(32'h40, 2'd2, 1'b1, 32'h200, 8'h00, 8'h00, 1'b0); tick(); idle();
    set_lookup(32'h40, 2'd2); #1;
    $display("txn jal 40 -> t=%0d tgt=%h", pred_taken, pred_target);
    checks++; if (pred_taken !== BTB_ON) begin failures++; $display("FAIL jal_taken got=%0d exp=%0d", pred_taken, BTB_ON); end
    checks++; if (pred_target !== (BTB_ON ? 32'h200 : 32'h44)) begin failures++; $display("FAIL jal_target got=%h", pred_target); end
    tick(); idle();
    set_upd(32'h440, 2'd2, 1'b1, 32'h300, 8'h00, 8'h00, 1'b0); tick(); idle();
    set_lookup(32'h40, 2'd2); #1;
    $display("txn conflict 40 -> t=%0d tgt=%h", pred_taken, pred_target);
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL conflict_old_taken got=%0d exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h44) begin failures++; $display("FAIL conflict_old_target got=%h exp=44", pred_target); end
    set_lookup(32'h440, 2'd3); #1;
    $display("txn conflict 440 -> t=%0d tgt=%h", pred_taken, pred_target);
    checks++; if (pred_taken !== BTB_ON) begin failures++; $display("FAIL conflict_new_taken got=%0d exp=%0d", pred_taken, BTB_ON); end
    checks++; if (pred_target !== (BTB_ON ? 32'h300 : 32'h444)) begin failures++; $display("FAIL conflict_new_target got=%h", pred_target); end
    set_lookup(32'h440, 2'd0); #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL nonctrl_taken got=%0d exp=0", pred_taken); end
    tick(); idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_upd(32'h80, 2'd3, 1'b1, 32'h500, 8'h00, 8'h00, 1'b0);
    set_lookup(32'h80, 2'd3); #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL b2b_btb_old got=%0d exp=0", pred_taken); end
    tick(); idle();
    set_upd(32'h40, 2'd1, 1'b1, 32'h80, 8'h10, 8'h00, 1'b0);
    set_lookup(32'h80, 2'd3); #1;
    $display("txn b2b 80 -> t=%0d tgt=%h", pred_taken, pred_target);
    checks++; if (pred_target !== (BTB_ON ? 32'h500 : 32'h84)) begin failures++; $display("FAIL b2b_btb_new got=%h", pred_target); end
    set_lookup(32'h40, 2'd1); #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL b2b_pht_old got=%0d exp=0", pred_taken); end
    tick(); idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_upd(32'h0, 2'd0, 1'b0, 32'h0, 8'h00, 8'h00, 1'b1); tick();
    end
    idle(); #1;
    $display("txn sat -> mis32=%0d mis4=%h", perf_mispredicts, s_perf_mispredicts);
    checks++; if (s_perf_mispredicts !== 4'hF) begin failures++; $display("FAIL sat_mis4 got=%h exp=f", s_perf_mispredicts); end
    checks++; if (perf_mispredicts !== 32'd20) begin failures++; $display("FAIL sat_mis32 got=%0d exp=20", perf_mispredicts); end
  endtask

  task automatic test_random();
    bit t;
    logic [31:0] tgt;
    int idx;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      rst          = ($urandom_range(0, 99) == 0);
      lookup_valid = ($urandom_range(0, 3) != 0);
      lookup_pc    = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      lookup_kind  = 2'($urandom_range(0, 3));
      upd_valid    = ($urandom_range(0, 2) != 0);
      upd_pc       = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
      upd_kind     = 2'($urandom_range(0, 3));
      upd_taken    = ($urandom_range(0, 2) != 0);
      upd_target   = $urandom;
      upd_pht_idx  = 8'($urandom_range(0, 31));
      upd_ghr      = 8'($urandom);
      upd_mispredict = ($urandom_range(0, 3) == 0);
      #1;
      model_predict(t, tgt, idx);
      $display("txn rnd %0d rst=%0d lk=%0d pc=%h k=%0d -> t=%0d tgt=%h ghr=%h", n, rst,
               lookup_valid, lookup_pc, lookup_kind, pred_taken, pred_target, pred_ghr);
      checks++; if (pred_taken !== t) begin failures++; $display("FAIL rnd_taken[%0d] got=%0d exp=%0d", n, pred_taken, t); end
      checks++; if (pred_target !== tgt) begin failures++; $display("FAIL rnd_target[%0d] got=%h exp=%h", n, pred_target, tgt); end
      checks++; if (pred_pht_idx !== 8'(idx)) begin failures++; $display("FAIL rnd_idx[%0d] got=%h exp=%h", n, pred_pht_idx, 8'(idx)); end
      checks++; if (pred_ghr !== 8'(m_ghr)) begin failures++; $display("FAIL rnd_ghr[%0d] got=%h exp=%h", n, pred_ghr, 8'(m_ghr)); end
      checks++; if (perf_lookups !== m_lk[31:0]) begin failures++; $display("FAIL rnd_perf_lk[%0d] got=%0d exp=%0d", n, perf_lookups, m_lk); end
      checks++; if (perf_mispredicts !== m_mis[31:0]) begin failures++; $display("FAIL rnd_perf_mis[%0d] got=%0d exp=%0d", n, perf_mispredicts, m_mis); end
      checks++; if (s_perf_lookups !== m_slk[3:0]) begin failures++; $display("FAIL rnd_sat_lk[%0d] got=%0d exp=%0d", n, s_perf_lookups, m_slk); end
      checks++; if (s_perf_mispredicts !== m_smis[3:0]) begin failures++; $display("FAIL rnd_sat_mis[%0d] got=%0d exp=%0d", n, s_perf_mispredicts, m_smis); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_training();
    test_spec_history();
    test_repair();
    test_btb_conflict();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gshare_btb_predictor.md
# gshare_btb_predictor

Parametrised gshare branch predictor with a direct-mapped branch target buffer, speculative global history and misprediction repair. It sits in the fetch/decode front end and succeeds the fixed 8-bit gshare used by the controller. Lookups are answered combinationally in the same cycle. Resolved outcomes arrive from EX/MEM on a separate update port and are committed on the next clock edge.

## Interface
- PC_W, 32: program-counter width.
- GHR_W, 8: global history length; must be ≤ PHT_IDX_W.
- PHT_IDX_W, 8: log2 of pattern-history-table entries (2-bit counters).
- BTB_IDX_W, 4: log2 of BTB entries.
- CNT_W, 32: performance-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  PC_W  PC of the instruction being predicted.
- lookup_kind  in  2  00 non-control, 01 conditional branch, 10 jal, 11 jalr.
- pred_taken  out  1  predicted redirect.
- pred_target  out  PC_W  next PC.
- pred_pht_idx  out  PHT_IDX_W  PHT index used; carried down the pipe.
- pred_ghr  out  GHR_W  GHR snapshot before this lookup; carried down the pipe.
- upd_valid  in  1  resolved control instruction.
- upd_pc  in  PC_W  its PC.
- upd_kind  in  2  encoding as lookup_kind.
- upd_taken  in  1  actual direction.
- upd_target  in  PC_W  actual target.
- upd_pht_idx  in  PHT_IDX_W  index returned from lookup.
- upd_ghr  in  GHR_W  snapshot returned from lookup.
- upd_mispredict  in  1  direction or target was wrong.
- perf_lookups  out  CNT_W  count of conditional-branch lookups.
- perf_mispredicts  out  CNT_W  count of mispredicts.

## Operation
**Index.** pht_idx = lookup_pc[PHT_IDX_W+1:2] XOR zero-extended GHR.

**BTB.**
- Direct-mapped. Index is pc[BTB_IDX_W+1:2]; tag is pc[PC_W-1:BTB_IDX_W+2].
- hit = valid && tag match.

**Prediction (combinational).**
- lookup_valid=0 or kind 00: pred_taken=0.
- kind 01: pred_taken = PHT[pht_idx][1] && hit.
- kind 10/11: pred_taken = hit.
- pred_target = pred_taken ? BTB target : lookup_pc+4, truncated to PC_W.

**Speculative GHR.** When lookup_valid && kind 01: GHR ← {GHR[GHR_W-2:0], pred_taken}.

**Update** (upd_valid):
- kind 01: PHT[upd_pht_idx] saturating +1 if upd_taken (max 3), −1 otherwise (min 0).
- kind ≠ 00 and upd_taken: write BTB entry {valid=1, tag, upd_target}; overwrite on conflict.
- upd_mispredict with kind 01: GHR ← {upd_ghr[GHR_W-2:0], upd_taken}.
- upd_mispredict with kind 10/11: GHR ← upd_ghr.

**Precedence.** A mispredict GHR repair overrides a same-cycle speculative shift; that cycle's lookup shift is discarded.

**Performance counters.**
- perf_lookups +1 per valid kind-01 lookup.
- perf_mispredicts +1 per upd_valid && upd_mispredict.
- Both saturate at all-ones.

## Timing
- Lookup is zero latency (combinational from lookup_pc and state).
- Update becomes visible to lookups from the cycle after the update edge.
- Same-cycle lookup and update to the same PHT index or BTB entry: the lookup sees the old value; no bypass.
- Reset, including mid-stream, in the cycle after rst:
  - all PHT counters = 01 (weakly not taken);
  - GHR = 0;
  - all BTB valid = 0;
  - perf counters = 0.
- Consequences after reset: pred_taken=0, pred_target=lookup_pc+4, pred_ghr=0.
- rst overrides any concurrent lookup or update.
- Neither port has a handshake or backpressure; the block accepts one lookup and one update every cycle.

## Configuration
**BP_BTB_EN defined:** the BTB behaves as above.

**BP_BTB_EN undefined:**
- No BTB storage.
- kind 01: pred_taken = PHT[pht_idx][1].
- kind 10/11: pred_taken = 0.
- pred_target = lookup_pc+4 always; decode computes the taken target.
- PHT, GHR and counter behaviour are unchanged.

## Test plan
1. **Reset:** assert rst, then lookup pc=0x100, kind 01 → pred_taken=0, pred_target=0x104, pred_ghr=0; perf counters read 0.
2. **Training:** three taken updates of a kind-01 branch at pc=0x40, target 0x80, with GHR held at 0 → next lookup of 0x40 gives pred_taken=1, pred_target=0x80. One further not-taken update drops the counter 3→2 and the lookup stays taken.
3. **Speculative history:** four consecutive kind-01 lookups predicted 1,0,1,1 → pred_ghr sequence 0x00, 0x01, 0x02, 0x05; GHR afterwards reads 0x0B.
4. **Repair precedence:** upd_mispredict with kind 01, upd_ghr=0x05, upd_taken=0, in the same cycle as a kind-01 lookup → next pred_ghr=0x0A; perf_mispredicts increments by 1.
5. **BTB conflict:** taken jal updates at 0x40 then 0x440 (BTB_IDX_W=4, same index, different tag) → lookup 0x40 misses (pred_taken=0); lookup 0x440 hits.
6. **Saturation and build variant:** with CNT_W=4, 20 mispredicts → perf_mispredicts=0xF. With BP_BTB_EN undefined, a trained jal at 0x40 → pred_taken=0, pred_target=0x44.
